// File: rtl/led_pulse_encoder_if.sv
// ---------------------------------------------------------------------------
// led_pulse_encoder_if
//   Word request channel into led_pulse_encoder. The master drives a word of
//   up to 8 short/long symbols; the slave answers with in_ready.
//
//   in_valid : master -> slave, word request
//   in_ready : slave -> master, encoder idle and able to take a word
//   in_data  : master -> slave, symbols LSB first (0 = short, 1 = long)
//   in_len   : master -> slave, symbol count 0..15 (clamped to 8 by slave)
// ---------------------------------------------------------------------------
interface led_pulse_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] in_len;

  modport master (output in_valid, in_data, in_len, input in_ready);
  modport slave  (input in_valid, in_data, in_len, output in_ready);
endinterface

// File: rtl/led_pulse_encoder.sv
// ---------------------------------------------------------------------------
// led_pulse_encoder
//   Plays a word of short/long symbols on a single LED line so a person can
//   read it by eye. Each symbol is a lit mark (SHORT_CYC or LONG_CYC cycles),
//   symbols are separated by GAP_CYC dark cycles and the word ends with
//   WORD_GAP_CYC dark cycles followed by a one-cycle done pulse.
//
//   clk   : system clock
//   rst   : asynchronous active-high reset (drops led immediately)
//   in_if : word request channel (slave side)
//   led   : LED drive, 1 = lit
//   busy  : a word is in progress (always the inverse of in_ready)
//   done  : one-cycle pulse in the cycle the encoder returns to idle
// ---------------------------------------------------------------------------
module led_pulse_encoder #(
  parameter int unsigned SHORT_CYC    = 10_000_000,
  parameter int unsigned LONG_CYC     = 50_000_000,
  parameter int unsigned GAP_CYC      = 10_000_000,
  parameter int unsigned WORD_GAP_CYC = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  led_pulse_encoder_if.slave   in_if,
  output logic                 led,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    WGAP
  } state_t;

  // Terminal counts: the duration counter runs 0..N-1 inside each state.
  localparam logic [31:0] SHORT_LAST = SHORT_CYC - 1;
  localparam logic [31:0] LONG_LAST  = LONG_CYC - 1;
  localparam logic [31:0] GAP_LAST   = GAP_CYC - 1;
  localparam logic [31:0] WGAP_LAST  = WORD_GAP_CYC - 1;

  state_t      state;
  logic [7:0]  sym_sr;     // remaining symbols, current one in bit 0
  logic [3:0]  remaining;  // symbols still to be played, including current
  logic [31:0] dur_cnt;
  logic        ready_q;

  logic [3:0]  len_clamped;
  logic [31:0] mark_last;

  assign len_clamped = (in_if.in_len > 4'd8) ? 4'd8 : in_if.in_len;
  assign mark_last   = sym_sr[0] ? LONG_LAST : SHORT_LAST;
  assign in_if.in_ready = ready_q;

  // NOTE: every register here is assigned with <= so all of them update
  // together from the values seen before the edge; a blocking = would let
  // later statements see half-updated state and break the cycle counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sym_sr    <= '0;
      remaining <= '0;
      dur_cnt   <= '0;
      led       <= 1'b0;
      ready_q   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A zero-length word is consumed without leaving IDLE.
          if (in_if.in_valid && ready_q && (in_if.in_len != 4'd0)) begin
            sym_sr    <= in_if.in_data;
            remaining <= len_clamped;
            dur_cnt   <= '0;
            led       <= 1'b1;
            ready_q   <= 1'b0;
            busy      <= 1'b1;
            state     <= MARK;
          end
        end

        MARK: begin
          if (dur_cnt == mark_last) begin
            dur_cnt   <= '0;
            sym_sr    <= sym_sr >> 1;
            remaining <= remaining - 4'd1;
            led       <= 1'b0;
            state     <= (remaining == 4'd1) ? WGAP : SPACE;
          end else begin
            dur_cnt <= dur_cnt + 32'd1;
          end
        end

        SPACE: begin
          if (dur_cnt == GAP_LAST) begin
            dur_cnt <= '0;
            led     <= 1'b1;
            state   <= MARK;
          end else begin
            dur_cnt <= dur_cnt + 32'd1;
          end
        end

        WGAP: begin
          if (dur_cnt == WGAP_LAST) begin
            dur_cnt <= '0;
            ready_q <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            dur_cnt <= dur_cnt + 32'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
